// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: control/datapath bundle between the control unit and the register file.
interface reg_file_wb_if #(parameter int WIDTH = 16);
    logic [7:0]       send_reg;
    logic             load_rega;
    logic             load_regb;
    logic             wt_reg;
    logic [3:0]       addr_reg;
    logic [1:0]       sel_mux4;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] lmd;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] wb_data;
    logic [3:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    modport master (
        output send_reg, load_rega, load_regb, wt_reg, addr_reg, sel_mux4,
               alu_out, lmd, npc, dbg_addr,
        input  reg_a, reg_b, wb_data, dbg_data
    );
    modport slave (
        input  send_reg, load_rega, load_regb, wt_reg, addr_reg, sel_mux4,
               alu_out, lmd, npc, dbg_addr,
        output reg_a, reg_b, wb_data, dbg_data
    );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: MIPS16 register file (R0-R7, IH, T, SP) with operand latches A/B
// and the write-back source selector.
module reg_file_wb #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] SP_INIT = 16'hBF00,
    parameter logic [WIDTH-1:0] IH_INIT = 16'h0000
) (
    input logic           clk,
    input logic           rst,
    reg_file_wb_if.slave  bus
);
    logic [WIDTH-1:0] file_q [16];
    logic [WIDTH-1:0] file_d [16];
    logic [WIDTH-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d, wb_data, rd_a, rd_b, rd_dbg;

    // 4'h8..4'hC have no storage: never written, always read as zero
    function automatic logic impl(input logic [3:0] a);
        return a <= 4'h7 || a >= 4'hD;
    endfunction

    always_comb begin
        wb_data = bus.sel_mux4 == 2'd0 ? bus.alu_out :
                  bus.sel_mux4 == 2'd1 ? bus.lmd :
                  bus.sel_mux4 == 2'd2 ? bus.npc : '0;
        rd_a    = impl(bus.send_reg[7:4]) ? file_q[bus.send_reg[7:4]] : '0;
        rd_b    = impl(bus.send_reg[3:0]) ? file_q[bus.send_reg[3:0]] : '0;
        rd_dbg  = impl(bus.dbg_addr) ? file_q[bus.dbg_addr] : '0;
        file_d  = file_q;
        if (bus.wt_reg && impl(bus.addr_reg))
            file_d[bus.addr_reg] = wb_data;
        reg_a_d = bus.load_rega ? rd_a : reg_a_q;
        reg_b_d = bus.load_regb ? rd_b : reg_b_q;
    end

    // latches sample the pre-write file contents: no write-to-read forwarding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++)
                file_q[i] <= '0;
            file_q[13] <= IH_INIT;
            file_q[15] <= SP_INIT;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
        end else begin
            file_q  <= file_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
        end
    end

    assign bus.reg_a    = reg_a_q;
    assign bus.reg_b    = reg_b_q;
    assign bus.wb_data  = wb_data;
    assign bus.dbg_data = rd_dbg;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_reg_file_wb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic obs = 1'b0;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    reg_file_wb_if #(.WIDTH(16)) bus();
    reg_file_wb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // kind: 0 reg_a, 1 reg_b, 2 dbg_data, 3 wb_data
    always @(negedge clk) begin
        if (obs) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: got an observation with no expectation queued");
            end else begin
                exp_t        e;
                string       n;
                logic [15:0] act;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act = e.kind == 2'd0 ? bus.reg_a :
                      e.kind == 2'd1 ? bus.reg_b :
                      e.kind == 2'd2 ? bus.dbg_data : bus.wb_data;
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, act, e.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [1:0] kind, input logic [3:0] a, input logic [15:0] v, input string n);
        if (kind == 2'd2) bus.dbg_addr = a;
        exp_q.push_back('{kind: kind, val: v});
        name_q.push_back(n);
        obs = 1'b1;
        @(negedge clk);
        #1;
        obs = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] sel, input logic [15:0] v);
        bus.wt_reg   = 1'b1;
        bus.addr_reg = a;
        bus.sel_mux4 = sel;
        bus.alu_out  = v;
        bus.lmd      = v;
        bus.npc      = v;
        step();
        bus.wt_reg   = 1'b0;
    endtask

    task automatic ld(input logic [7:0] s, input logic la, input logic lb);
        bus.send_reg  = s;
        bus.load_rega = la;
        bus.load_regb = lb;
        step();
        bus.load_rega = 1'b0;
        bus.load_regb = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.send_reg = '0; bus.load_rega = 0; bus.load_regb = 0; bus.wt_reg = 0;
        bus.addr_reg = '0; bus.sel_mux4 = '0; bus.alu_out = '0; bus.lmd = '0;
        bus.npc = '0; bus.dbg_addr = '0;
        step();
        step();
        rst = 1'b1;
        step();
        // make state non-trivial, then reset asynchronously mid-cycle
        wr(4'h3, 2'd0, 16'h7777);
        wr(4'hF, 2'd0, 16'h1111);
        ld(8'h33, 1, 1);
        chk(0, 0, 16'h7777, "pre_reset_reg_a");
        step();
        #2 rst = 1'b0;
        chk(0, 0, 16'h0000, "reset_reg_a");
        chk(1, 0, 16'h0000, "reset_reg_b");
        chk(2, 4'h3, 16'h0000, "reset_r3");
        chk(2, 4'hF, 16'hBF00, "reset_sp");
        chk(2, 4'hD, 16'h0000, "reset_ih");
        step();
        rst = 1'b1;
        // write then load both operands
        bus.sel_mux4 = 2'd0;
        bus.alu_out  = 16'h1234;
        bus.wt_reg   = 1'b1;
        bus.addr_reg = 4'h5;
        chk(3, 0, 16'h1234, "wb_sel0");
        step();
        bus.wt_reg = 1'b0;
        ld(8'h5F, 1, 1);
        chk(0, 0, 16'h1234, "load_a_r5");
        chk(1, 0, 16'hBF00, "load_b_sp");
        ld(8'h55, 1, 1);
        chk(0, 0, 16'h1234, "same_reg_a");
        chk(1, 0, 16'h1234, "same_reg_b");
        // write-back mux sources into T
        wr(4'hE, 2'd1, 16'hA5A5);
        chk(2, 4'hE, 16'hA5A5, "mux_lmd");
        wr(4'hE, 2'd2, 16'h0042);
        chk(2, 4'hE, 16'h0042, "mux_npc");
        wr(4'hE, 2'd3, 16'hDEAD);
        chk(2, 4'hE, 16'h0000, "mux_reserved");
        // unimplemented address
        wr(4'h9, 2'd0, 16'hFFFF);
        chk(2, 4'h9, 16'h0000, "unimpl_r9");
        chk(2, 4'h5, 16'h1234, "unimpl_r5_kept");
        chk(2, 4'hF, 16'hBF00, "unimpl_sp_kept");
        chk(2, 4'hD, 16'h0000, "unimpl_ih_kept");
        ld(8'h9C, 1, 1);
        chk(0, 0, 16'h0000, "unimpl_load_a");
        // same-edge read/write collision
        wr(4'h1, 2'd0, 16'h0001);
        bus.send_reg  = 8'h10;
        bus.load_rega = 1'b1;
        wr(4'h1, 2'd0, 16'h00FF);
        bus.load_rega = 1'b0;
        chk(0, 0, 16'h0001, "collision_old");
        chk(2, 4'h1, 16'h00FF, "collision_file");
        ld(8'h10, 1, 0);
        chk(0, 0, 16'h00FF, "collision_reload");
        chk(1, 0, 16'h0000, "reg_b_held");
        // hold while R1 changes, with a multi-cycle write
        bus.wt_reg   = 1'b1;
        bus.addr_reg = 4'h1;
        bus.sel_mux4 = 2'd0;
        for (int i = 0; i < 10; i++) begin
            bus.alu_out = 16'h0100 + 16'(i);
            step();
        end
        bus.wt_reg = 1'b0;
        chk(0, 0, 16'h00FF, "hold_reg_a");
        chk(2, 4'h1, 16'h0109, "multicycle_write");
        // reset pulse while a write is pending
        bus.wt_reg   = 1'b1;
        bus.addr_reg = 4'h1;
        bus.alu_out  = 16'hBEEF;
        #1 rst = 1'b0;
        @(posedge clk);
        #2;
        bus.wt_reg = 1'b0;
        rst = 1'b1;
        chk(2, 4'h1, 16'h0000, "reset_write_lost");
        chk(0, 0, 16'h0000, "reset2_reg_a");
        wr(4'h1, 2'd0, 16'h0055);
        chk(2, 4'h1, 16'h0055, "write_resumes");
        step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
